cronometro_ctrl: RTL and testbench
==================================

# cronometro_ctrl

Run/pause/lap/clear controller for the stopwatch. It converts debounced button pulses into the count-enable, clear and display-hold controls that drive the seconds/minutes BCD counter chain. It also prescales the system clock to the 1 Hz count tick. It sits between the debounced button inputs and the counter/display datapath.

## Interface
- `DIV`, default 50_000_000: clock cycles per count tick; must be ≥ 2.
- `PW`, default `$clog2(DIV)`: prescaler width.

Ports:
- `clk` in 1: system clock; all logic on posedge.
- `reset` in 1: asynchronous, active-low; `reset`=0 forces the reset state immediately.
- `btn_ss` in 1: start/stop request; one-cycle pulse, already debounced and synchronous.
- `btn_lap` in 1: lap request; one-cycle pulse.
- `btn_clr` in 1: clear request; one-cycle pulse.
- `at_max` in 1: counter chain reports 99:59 (level, from counters).
- `tick` out 1: one-cycle count enable to the seconds counter.
- `cnt_clear` out 1: one-cycle synchronous clear to all counters.
- `snap` out 1: one-cycle capture strobe for the display latch.
- `freeze` out 1: level; display shows the latched value instead of the live one.
- `running` out 1: level; high in RUN or LAP.
- `state` out 3: current state encoding, for debug and LEDs.

## Operation
- All outputs are registered. Reset values: `tick`=0, `cnt_clear`=0, `snap`=0, `freeze`=0, `running`=0, `state`=IDLE, prescaler=0.
- Buttons are sampled at each posedge. Priority on the same edge is `btn_clr` > `btn_ss` > `btn_lap`. Lower-priority requests on that edge are dropped.
- **IDLE**
  - `btn_ss` → RUN.
  - `btn_clr` → `cnt_clear` pulse, stay in IDLE.
  - `btn_lap` is ignored.
- **RUN**
  - `btn_ss` → PAUSE.
  - `btn_lap` → LAP, with `snap` pulse and `freeze`=1.
  - `btn_clr` is ignored.
- **LAP**: counting continues while the display is frozen.
  - `btn_lap` → LAP with a fresh `snap` pulse.
  - `btn_ss` → PAUSE with `freeze`=0.
  - `btn_clr` is ignored.
- **PAUSE**
  - `btn_ss` → RUN.
  - `btn_clr` → IDLE with `cnt_clear` pulse and prescaler=0.
  - `btn_lap` is ignored.
- **FULL**
  - `btn_clr` → IDLE with `cnt_clear` pulse and prescaler=0.
  - All other buttons are ignored.
- **Prescaler**
  - Counts 0..DIV-1 only in RUN/LAP.
  - Holds its value in PAUSE and FULL.
  - Cleared only by reset or by an accepted clear.
- **Wrap**: in RUN/LAP with prescaler == DIV-1 and no accepted state change on that edge:
  - If `at_max`=0: prescaler → 0 and `tick` = 1 on the next cycle.
  - If `at_max`=1: no `tick`, state → FULL, `freeze`=0, prescaler → 0.
- **Stop on a wrap edge**: an accepted `btn_ss` leaves the state as PAUSE, issues no tick, and holds the prescaler at DIV-1. The first RUN edge after resume then issues the tick.
- `running` = (next state ∈ {RUN, LAP}), registered.
- `freeze` is high only while in LAP.

## Timing
- Button to state change: 1 cycle. The button is sampled at edge N; `state`, `running`, `freeze`, `snap` and `cnt_clear` are valid after edge N.
- Tick period in uninterrupted RUN/LAP: exactly DIV cycles. The first tick comes DIV cycles after the RUN entry edge when starting from prescaler=0.
- `tick`, `snap` and `cnt_clear` are each exactly 1 cycle wide and never asserted together except `snap` with `tick`.
- `reset` deassertion: the first active edge afterwards sees state IDLE. No pulses are generated by reset.
- Reset mid-RUN: all outputs drop to their reset values asynchronously. The counters are not cleared by this block (they share `reset`).

## Structure
- Package `cronometro_pkg`:
  - State encoding: IDLE=0, RUN=1, PAUSE=2, LAP=3, FULL=4; width 3.
  - Default `DIV`.
- Sub-module `cronometro_prescaler`:
  - Ports: `clk`, `reset`, `en`, `clr`, `wrap_o`.
  - `wrap_o` is combinational (prescaler==DIV-1).
- The top level holds the FSM and output registers.

## Test plan
- DIV=4, reset, `btn_ss` at cycle 2 → `running`=1 after edge 2; `tick` high for one cycle every 4 cycles; first tick 4 cycles after RUN entry.
- RUN, `btn_ss` pulse on the cycle prescaler==3 → PAUSE, no tick. Resume `btn_ss` → tick on the first RUN edge, then every 4 cycles.
- RUN, `btn_lap` → `snap` 1 cycle and `freeze`=1 while ticks continue. Second `btn_lap` → second `snap`. `btn_ss` → PAUSE with `freeze`=0.
- `btn_clr` and `btn_ss` on the same edge in PAUSE → IDLE, `cnt_clear` 1 cycle, `running`=0. `btn_clr` in RUN → ignored.
- RUN with `at_max`=1 at prescaler wrap → no tick, `state`=FULL. `btn_ss`/`btn_lap` ignored. `btn_clr` → IDLE with `cnt_clear`.
- `reset`=0 asserted mid-LAP between edges → `freeze`, `running`, `tick` go 0 immediately and `state`=IDLE. After release, the first `btn_ss` → RUN with the first tick after 4 cycles.

Source files
------------

// File: rtl/cronometro_pkg.sv
// Shared types and constants for the stopwatch run/pause/lap/clear controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package cronometro_pkg;

    localparam int STATE_W     = 3;
    localparam int DIV_DEFAULT = 50_000_000;

    // Encoding is visible on the state output (debug/LEDs), so values are fixed.
    typedef enum logic [STATE_W-1:0] {
        ST_IDLE  = 3'd0,
        ST_RUN   = 3'd1,
        ST_PAUSE = 3'd2,
        ST_LAP   = 3'd3,
        ST_FULL  = 3'd4
    } state_t;

    // True in the states where the prescaler advances and ticks are produced.
    function automatic logic is_counting(input state_t s);
        return (s == ST_RUN) || (s == ST_LAP);
    endfunction

endpackage

// File: rtl/cronometro_ctrl_if.sv
// Button/at_max inputs and control outputs between the stopwatch controller and its neighbours.
// Latency: n/a (wiring only).
// Backpressure: none; all signals are single-cycle pulses or levels.
// Ports: master = button/counter side (drives btn_*, at_max); slave = controller.
interface cronometro_ctrl_if;
    import cronometro_pkg::*;

    logic               btn_ss;
    logic               btn_lap;
    logic               btn_clr;
    logic               at_max;
    logic               tick;
    logic               cnt_clear;
    logic               snap;
    logic               freeze;
    logic               running;
    logic [STATE_W-1:0] state;

    modport master (
        output btn_ss, btn_lap, btn_clr, at_max,
        input  tick, cnt_clear, snap, freeze, running, state
    );

    modport slave (
        input  btn_ss, btn_lap, btn_clr, at_max,
        output tick, cnt_clear, snap, freeze, running, state
    );

endinterface

// File: rtl/cronometro_prescaler.sv
// Free-running 0..DIV-1 counter that paces the stopwatch count tick.
// Latency: wrap_o is combinational from the current count (high when count == DIV-1).
// Backpressure: none; en freezes the count, clr forces it to zero (clr wins).
// Ports: clk, reset (async active-low), en, clr, wrap_o.
module cronometro_prescaler
    import cronometro_pkg::*;
#(
    parameter int DIV = DIV_DEFAULT,
    parameter int PW  = $clog2(DIV)
)(
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic clr,
    output logic wrap_o
);

    localparam logic [PW-1:0] LAST = PW'(DIV - 1);

    logic [PW-1:0] r_cnt;

    assign wrap_o = (r_cnt == LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (en) begin
            r_cnt <= wrap_o ? '0 : r_cnt + PW'(1);
        end
    end

endmodule

// File: rtl/cronometro_ctrl.sv
// Stopwatch controller: turns button pulses into tick/clear/snap/freeze controls for the BCD counters.
// Latency: one cycle from button sample to registered outputs; tick every DIV cycles while counting.
// Backpressure: none; buttons are one-shot requests, ignored requests are dropped.
// Ports: clk, reset (async active-low), bus (slave side of cronometro_ctrl_if).
module cronometro_ctrl
    import cronometro_pkg::*;
#(
    parameter int DIV = DIV_DEFAULT,
    parameter int PW  = $clog2(DIV)
)(
    input  logic              clk,
    input  logic              reset,
    cronometro_ctrl_if.slave  bus
);

    state_t r_state;
    state_t w_state_nxt;
    logic   r_tick;
    logic   r_cnt_clear;
    logic   r_snap;
    logic   r_freeze;
    logic   r_running;

    logic   w_tick_nxt;
    logic   w_clear_nxt;
    logic   w_snap_nxt;
    logic   w_pre_en;
    logic   w_pre_clr;
    logic   w_wrap;

    // Highest-priority button present on an edge wins; the others are dropped
    // even when the winner turns out to be ignored in the current state.
    logic   w_clr;
    logic   w_ss;
    logic   w_lap;

    assign w_clr = bus.btn_clr;
    assign w_ss  = bus.btn_ss  & ~bus.btn_clr;
    assign w_lap = bus.btn_lap & ~bus.btn_ss & ~bus.btn_clr;

    cronometro_prescaler #(
        .DIV (DIV),
        .PW  (PW)
    ) u_prescaler (
        .clk    (clk),
        .reset  (reset),
        .en     (w_pre_en),
        .clr    (w_pre_clr),
        .wrap_o (w_wrap)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_tick_nxt  = 1'b0;
        w_clear_nxt = 1'b0;
        w_snap_nxt  = 1'b0;
        w_pre_en    = 1'b0;
        w_pre_clr   = 1'b0;

        unique case (r_state)
            ST_IDLE: begin
                if (w_clr) begin
                    w_clear_nxt = 1'b1;
                    w_pre_clr   = 1'b1;
                end else if (w_ss) begin
                    w_state_nxt = ST_RUN;
                end
            end

            ST_RUN, ST_LAP: begin
                if (w_ss) begin
                    // Stopping freezes the prescaler, even at DIV-1: the tick
                    // owed on this edge is issued on the first edge after resume.
                    w_state_nxt = ST_PAUSE;
                end else begin
                    w_pre_en = 1'b1;
                    if (w_wrap && bus.at_max) begin
                        // 99:59 reached: stop without a tick; display goes live.
                        w_state_nxt = ST_FULL;
                    end else begin
                        w_tick_nxt = w_wrap;
                        if (w_lap) begin
                            w_state_nxt = ST_LAP;
                            w_snap_nxt  = 1'b1;
                        end
                    end
                end
            end

            ST_PAUSE: begin
                if (w_clr) begin
                    w_state_nxt = ST_IDLE;
                    w_clear_nxt = 1'b1;
                    w_pre_clr   = 1'b1;
                end else if (w_ss) begin
                    w_state_nxt = ST_RUN;
                end
            end

            ST_FULL: begin
                if (w_clr) begin
                    w_state_nxt = ST_IDLE;
                    w_clear_nxt = 1'b1;
                    w_pre_clr   = 1'b1;
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_IDLE;
            r_tick      <= 1'b0;
            r_cnt_clear <= 1'b0;
            r_snap      <= 1'b0;
            r_freeze    <= 1'b0;
            r_running   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_tick      <= w_tick_nxt;
            r_cnt_clear <= w_clear_nxt;
            r_snap      <= w_snap_nxt;
            r_freeze    <= (w_state_nxt == ST_LAP);
            r_running   <= is_counting(w_state_nxt);
        end
    end

    assign bus.state     = r_state;
    assign bus.tick      = r_tick;
    assign bus.cnt_clear = r_cnt_clear;
    assign bus.snap      = r_snap;
    assign bus.freeze    = r_freeze;
    assign bus.running   = r_running;

endmodule

// File: tb/tb_cronometro_ctrl.sv
// Self-checking bench for cronometro_ctrl with DIV=4.
// Latency: n/a.
// Backpressure: n/a.
module tb_cronometro_ctrl;

    localparam int DIV = 4;

    localparam int S_IDLE  = 0;
    localparam int S_RUN   = 1;
    localparam int S_PAUSE = 2;
    localparam int S_LAP   = 3;
    localparam int S_FULL  = 4;

    logic clk;
    logic reset;

    int n_tests;
    int n_fail;

    cronometro_ctrl_if bus ();

    cronometro_ctrl #(.DIV(DIV)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Observed outputs packed as {state, running, freeze, snap, cnt_clear, tick}.
    logic [7:0] obs;
    assign obs = {bus.state, bus.running, bus.freeze, bus.snap, bus.cnt_clear, bus.tick};

    // Reference model: stopwatch mode plus elapsed prescaler cycles.
    int m_mode;
    int m_pre;
    bit e_tick, e_snap, e_clear;

    function automatic logic [7:0] model_obs();
        bit counting;
        counting = (m_mode == S_RUN) || (m_mode == S_LAP);
        return {m_mode[2:0], counting, (m_mode == S_LAP), e_snap, e_clear, e_tick};
    endfunction

    task automatic model_reset();
        m_mode  = S_IDLE;
        m_pre   = 0;
        e_tick  = 0;
        e_snap  = 0;
        e_clear = 0;
    endtask

    task automatic model_step(input bit ss, input bit lap, input bit clr, input bit am);
        bit take_ss;
        bit take_lap;
        bit at_wrap;
        take_ss  = ss && !clr;
        take_lap = lap && !ss && !clr;
        e_tick   = 0;
        e_snap   = 0;
        e_clear  = 0;
        if (clr && (m_mode == S_IDLE || m_mode == S_PAUSE || m_mode == S_FULL)) begin
            m_mode  = S_IDLE;
            m_pre   = 0;
            e_clear = 1;
        end else if (m_mode == S_RUN || m_mode == S_LAP) begin
            if (take_ss) begin
                m_mode = S_PAUSE;
            end else begin
                at_wrap = (m_pre == DIV - 1);
                m_pre   = (m_pre + 1) % DIV;
                if (at_wrap && am) begin
                    m_mode = S_FULL;
                end else begin
                    e_tick = at_wrap;
                    if (take_lap) begin
                        m_mode = S_LAP;
                        e_snap = 1;
                    end
                end
            end
        end else if (take_ss && (m_mode == S_IDLE || m_mode == S_PAUSE)) begin
            m_mode = S_RUN;
        end
    endtask

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %02h expected %02h", name, act, exp);
        end
    endtask

    // One clock edge: drive at negedge, sample at the following negedge.
    task automatic cycle(input string name, input bit ss, input bit lap, input bit clr, input bit am);
        bus.btn_ss  = ss;
        bus.btn_lap = lap;
        bus.btn_clr = clr;
        bus.at_max  = am;
        model_step(ss, lap, clr, am);
        @(posedge clk);
        @(negedge clk);
        bus.btn_ss  = 1'b0;
        bus.btn_lap = 1'b0;
        bus.btn_clr = 1'b0;
        check(name, obs, model_obs());
    endtask

    typedef struct packed {
        bit       ss;
        bit       lap;
        bit       clr;
        bit       am;
        bit [2:0] st;
        bit       tick;
        bit       snap;
        bit       clear;
        bit       frz;
        bit       run;
    } vec_t;

    vec_t tbl [13];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_tests = 0;
        n_fail  = 0;
        //            ss    lap   clr   am    state  tick  snap  clear frz   run
        tbl[0]  = '{1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[1]  = '{1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[2]  = '{1'b1, 1'b0, 1'b0, 1'b0, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 3'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[7]  = '{1'b0, 1'b1, 1'b0, 1'b0, 3'd3, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        tbl[8]  = '{1'b0, 1'b0, 1'b1, 1'b0, 3'd3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        tbl[9]  = '{1'b0, 1'b1, 1'b0, 1'b0, 3'd3, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        tbl[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 3'd3, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        tbl[11] = '{1'b1, 1'b0, 1'b0, 1'b0, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[12] = '{1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

        reset       = 1'b0;
        bus.btn_ss  = 1'b0;
        bus.btn_lap = 1'b0;
        bus.btn_clr = 1'b0;
        bus.at_max  = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        check("reset_state", obs, 8'h00);
        reset = 1'b1;

        // Table: clear in IDLE, start, first tick, lap/snap, ignored clear, pause, clear+ss.
        for (int i = 0; i < 13; i++) begin
            cycle($sformatf("tbl_model_%0d", i), tbl[i].ss, tbl[i].lap, tbl[i].clr, tbl[i].am);
            check($sformatf("tbl_%0d", i), obs,
                  {tbl[i].st, tbl[i].run, tbl[i].frz, tbl[i].snap, tbl[i].clear, tbl[i].tick});
        end

        // Stop exactly on the wrap edge, then resume: tick owed on first RUN edge.
        cycle("sw_start", 1, 0, 0, 0);
        cycle("sw_p1", 0, 0, 0, 0);
        cycle("sw_p2", 0, 0, 0, 0);
        cycle("sw_p3", 0, 0, 0, 0);
        cycle("sw_stop", 1, 0, 0, 0);
        check("sw_stop_no_tick", {bus.state, bus.tick}, {3'd2, 1'b0});
        cycle("sw_resume", 1, 0, 0, 0);
        check("sw_resume_no_tick", {bus.state, bus.tick}, {3'd1, 1'b0});
        cycle("sw_first_edge", 0, 0, 0, 0);
        check("sw_owed_tick", {7'd0, bus.tick}, 8'd1);
        for (int k = 0; k < 3; k++) cycle("sw_gap", 0, 0, 0, 0);
        cycle("sw_period", 0, 0, 0, 0);
        check("sw_period_tick", {7'd0, bus.tick}, 8'd1);

        // Clear ignored in RUN; at_max at wrap -> FULL; only clear leaves FULL.
        cycle("run_clr", 0, 0, 1, 0);
        check("run_clr_ignored", {bus.state, bus.cnt_clear}, {3'd1, 1'b0});
        cycle("am_p2", 0, 0, 0, 0);
        cycle("am_p3", 0, 0, 0, 0);
        cycle("am_wrap", 0, 0, 0, 1);
        check("full_entry", obs, {3'd4, 5'b00000});
        cycle("full_ss", 1, 0, 0, 1);
        cycle("full_lap", 0, 1, 0, 1);
        check("full_stays", {5'd0, bus.state}, 8'd4);
        cycle("full_clr", 0, 0, 1, 0);
        check("full_clr_idle", obs, {3'd0, 5'b00010});

        // Asynchronous reset between edges while in LAP.
        cycle("rl_start", 1, 0, 0, 0);
        cycle("rl_lap", 0, 1, 0, 0);
        #2 reset = 1'b0;
        #1 check("async_reset", obs, 8'h00);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        model_reset();
        cycle("post_reset_idle", 0, 0, 0, 0);
        check("post_reset_state", obs, 8'h00);
        cycle("pr_start", 1, 0, 0, 0);
        for (int k = 0; k < 3; k++) cycle("pr_gap", 0, 0, 0, 0);
        cycle("pr_tick", 0, 0, 0, 0);
        check("pr_first_tick", {bus.state, bus.running, bus.tick}, {3'd1, 1'b1, 1'b1});

        // Randomised traffic against the reference model.
        for (int k = 0; k < 600; k++) begin
            cycle($sformatf("rand_%0d", k),
                  ($urandom_range(0, 5) == 0),
                  ($urandom_range(0, 5) == 0),
                  ($urandom_range(0, 9) == 0),
                  ($urandom_range(0, 7) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
